// File: rtl/lbc_pkg.sv
// Shared constants for the LED board controller serial receiver: latch commands,
// default widths and the receiver FSM state type.
package lbc_pkg;

    localparam int unsigned LBC_WORD_W = 48;
    localparam int unsigned LBC_CMD_W  = 4;

    localparam int unsigned WRTGS     = 1;
    localparam int unsigned LATGS     = 3;
    localparam int unsigned WRTFC     = 5;
    localparam int unsigned LINERESET = 7;
    localparam int unsigned READFC    = 11;
    localparam int unsigned TMGRST    = 13;
    localparam int unsigned FCWRTEN   = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        LATCH = 1'b1
    } rx_state_e;

endpackage

// File: rtl/lbc_serial_rx_if.sv
// Serial-in / captured-word bundle of lbc_serial_rx; frame_err present only
// when LBC_RX_FRAME_ERR_EN is defined.
interface lbc_serial_rx_if
    import lbc_pkg::*;
#(
    parameter int WORD_W = LBC_WORD_W,
    parameter int CMD_W  = LBC_CMD_W
);
    logic              sclk;
    logic              sin;
    logic              lat;
    logic [WORD_W-1:0] word;
    logic [CMD_W-1:0]  cmd;
    logic              valid;
`ifdef LBC_RX_FRAME_ERR_EN
    logic              frame_err;

    modport master (output sclk, sin, lat, input word, cmd, valid, frame_err);
    modport slave  (input sclk, sin, lat, output word, cmd, valid, frame_err);
`else
    modport master (output sclk, sin, lat, input word, cmd, valid);
    modport slave  (input sclk, sin, lat, output word, cmd, valid);
`endif
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes; strobes stay quiet
// until the pipeline has refilled after reset so a level present at release is not an edge.
module sync_edge (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic       s1;
    logic       s2;
    logic [1:0] arm;

    // Strobes are computed from s1 vs s2 so they line up with s2 changing,
    // giving edge-to-strobe latency of two clk.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            arm  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            arm  <= {arm[0], 1'b1};
            rise <= arm[1] & s1 & ~s2;
            fall <= arm[1] & ~s1 & s2;
        end
    end

    assign level = s2;

endmodule

// File: rtl/lbc_serial_rx.sv
// LED board controller serial receiver: shifts sin on sclk, counts sclk edges during lat
// and captures word/cmd on lat fall. Define LBC_RX_FRAME_ERR_EN to add the frame_err output.
module lbc_serial_rx
    import lbc_pkg::*;
#(
    parameter int WORD_W = LBC_WORD_W,
    parameter int CMD_W  = LBC_CMD_W
) (
    input  logic            clk,
    input  logic            nrst,
    lbc_serial_rx_if.slave  bus
);
    logic       sclk_rise;
    logic       lat_rise;
    logic       lat_fall;
    logic       sin_level;
    logic [4:0] sync_unused;

    sync_edge u_sync_sclk (
        .clk(clk), .nrst(nrst), .d(bus.sclk),
        .level(sync_unused[0]), .rise(sclk_rise), .fall(sync_unused[1])
    );
    sync_edge u_sync_sin (
        .clk(clk), .nrst(nrst), .d(bus.sin),
        .level(sin_level), .rise(sync_unused[2]), .fall(sync_unused[3])
    );
    sync_edge u_sync_lat (
        .clk(clk), .nrst(nrst), .d(bus.lat),
        .level(sync_unused[4]), .rise(lat_rise), .fall(lat_fall)
    );

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [CMD_W-1:0]  cnt;
    logic [CMD_W-1:0]  cnt_nxt;
    logic              capture;
    logic [WORD_W-1:0] word_q;
    logic [CMD_W-1:0]  cmd_q;
    logic              valid_q;

    // Capture uses the next-state shift/count so an sclk edge coinciding
    // with the lat fall is included in the snapshot.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (sclk_rise) begin
            shreg_nxt = {shreg[WORD_W-2:0], sin_level};
        end
        case (state)
            IDLE: begin
                if (lat_rise) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end
            end
            LATCH: begin
                if (sclk_rise && (cnt != '1)) begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (lat_fall) begin
                    state_nxt = IDLE;
                    capture   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            word_q  <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            valid_q <= capture;
            if (capture) begin
                word_q <= shreg_nxt;
                cmd_q  <= cnt_nxt;
            end
        end
    end

    assign bus.word  = word_q;
    assign bus.cmd   = cmd_q;
    assign bus.valid = valid_q;

`ifdef LBC_RX_FRAME_ERR_EN
    logic [7:0] bit_cnt;
    logic       err_pend;
    logic       frame_err_q;

    // Frame length is judged on edges seen before lat rises; the count
    // restarts at each capture.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt     <= '0;
            err_pend    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (capture) begin
                bit_cnt     <= '0;
                frame_err_q <= err_pend;
            end else if (sclk_rise && (bit_cnt != '1)) begin
                bit_cnt <= bit_cnt + 8'd1;
            end
            if ((state == IDLE) && lat_rise) begin
                err_pend <= ({24'd0, bit_cnt} != 32'(WORD_W));
            end
        end
    end

    assign bus.frame_err = frame_err_q;
`endif

endmodule
